// File: rtl/spi_slave_param.sv
// SPI slave front end: MOSI frames -> rx_data/rx_valid (FW cycles after CHK_CMD), RAM data -> MISO.
// Define SPI_SLAVE_PARITY_EN for a trailing odd-parity bit on MOSI frames and on MISO data.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              cmd_err,
  output logic              timeout_err,
  output logic              parity_err
);

  localparam int FW = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = FW + PAR;
  localparam int SLEN = DATA_W + PAR;
  localparam int BW   = $clog2(FLEN + 1);
  localparam int SW   = $clog2(SLEN + 1);
  localparam int TW   = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
  } state_t;

  state_t            state;
  logic              addr_flag;
  logic [FLEN-2:0]   shift;
  logic [BW-1:0]     bit_cnt;
  logic [SW-1:0]     send_cnt;
  logic [TW-1:0]     to_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [FLEN-1:0]   rcv;
  logic [FW-1:0]     frame;
  logic              last_bit;
  logic              cmd_ok;
  logic              par_ok;
`ifdef SPI_SLAVE_PARITY_EN
  logic              tx_par;
`endif

  // rcv is the complete frame (plus parity bit, if any) on the cycle the last bit arrives
  assign rcv      = {shift, mosi};
  assign frame    = rcv[FLEN-1 -: FW];
  assign last_bit = (bit_cnt == BW'(FLEN - 1));
  assign cmd_ok   = (state == WRITE) || ((state == READ_DATA) == frame[FW-2]);
  assign busy     = (state != IDLE);

`ifdef SPI_SLAVE_PARITY_EN
  assign par_ok = ^rcv;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_flag   <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      send_cnt    <= '0;
      to_cnt      <= '0;
      tx_sh       <= '0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err  <= 1'b0;
      tx_par      <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (state != IDLE && ss_n) begin
        // deselect aborts anything in flight; addr_flag survives
        state    <= IDLE;
        shift    <= '0;
        bit_cnt  <= '0;
        send_cnt <= '0;
        to_cnt   <= '0;
        tx_sh    <= '0;
        miso     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!ss_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            shift   <= {{(FLEN-2){1'b0}}, mosi};
            bit_cnt <= BW'(1);
            if (!mosi)          state <= WRITE;
            else if (addr_flag) state <= READ_DATA;
            else                state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!last_bit) begin
              shift   <= rcv[FLEN-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              shift   <= '0;
              bit_cnt <= '0;
              state   <= DONE;
              if (!par_ok) begin
`ifdef SPI_SLAVE_PARITY_EN
                parity_err <= 1'b1;
`endif
              end else if (!cmd_ok) begin
                cmd_err <= 1'b1;
              end else begin
                rx_data  <= frame;
                rx_valid <= 1'b1;
                if (state == READ_ADD) addr_flag <= 1'b1;
                if (state == READ_DATA) begin
                  state  <= WAIT_TX;
                  to_cnt <= '0;
                end
              end
            end
          end
          WAIT_TX: begin
            // tx_valid on the final allowed cycle still wins over the timeout
            if (tx_valid) begin
              tx_sh    <= tx_data;
              miso     <= (MSB_FIRST != 0) ? tx_data[DATA_W-1] : tx_data[0];
              send_cnt <= '0;
              to_cnt   <= '0;
              state    <= SEND;
`ifdef SPI_SLAVE_PARITY_EN
              tx_par   <= ~^tx_data;
`endif
            end else if (to_cnt == TW'(TX_TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              addr_flag   <= 1'b0;
              to_cnt      <= '0;
              state       <= DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          SEND: begin
            if (send_cnt == SW'(SLEN - 1)) begin
              miso      <= 1'b0;
              addr_flag <= 1'b0;
              send_cnt  <= '0;
              tx_sh     <= '0;
              state     <= DONE;
            end else begin
              send_cnt <= send_cnt + 1'b1;
              if (MSB_FIRST != 0) begin
                tx_sh <= tx_sh << 1;
                miso  <= tx_sh[DATA_W-2];
              end else begin
                tx_sh <= tx_sh >> 1;
                miso  <= tx_sh[1];
              end
`ifdef SPI_SLAVE_PARITY_EN
              if (send_cnt == SW'(DATA_W - 1)) miso <= tx_par;
`endif
            end
          end
          DONE: begin
            miso <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: directed and random transactions vs. a frame-level timing model.
`timescale 1ns/1ps
module tb_spi_slave_param;

  localparam int DATA_W     = 8;
  localparam int MSB_FIRST  = 1;
  localparam int TX_TIMEOUT = 16;
  localparam int FW = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN  = FW + PAR;
  localparam int SLEN  = DATA_W + PAR;
  localparam int LFULL = FLEN + TX_TIMEOUT + SLEN + 2;
  localparam int MAXC  = LFULL + 8;
  localparam int OW    = FW + 6;

  logic              clk = 1'b0;
  logic              rst, ss_n, mosi, tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              miso, rx_valid, busy, cmd_err, timeout_err, parity_err;
  logic [FW-1:0]     rx_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit            m_flag;
  logic [FW-1:0] m_rx;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .tx_data(tx_data), .tx_valid(tx_valid),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .cmd_err(cmd_err),
    .timeout_err(timeout_err), .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] obs();
    return {rx_data, rx_valid, cmd_err, timeout_err, parity_err, miso, busy};
  endfunction

  // One transaction: ss_n low for edges 0..L-1, frame bits on edges 1..FLEN, tx_valid d cycles
  // into WAIT_TX (d<0: never), optional reset on edge rst_at. Sample i reflects state after edge i.
  task automatic run_txn(input string name, input logic [FW-1:0] frame, input bit bad_par,
                         input int d, input int L, input int rst_at, input logic [DATA_W-1:0] tx_val);
    bit            rxv [MAXC], cerr [MAXC], terr [MAXC], perr [MAXC], mi [MAXC];
    logic [FW-1:0] rxd [MAXC];
    logic [OW-1:0] ex  [MAXC];
    bit            sb  [DATA_W+1];
    logic [FLEN-1:0] fb;
    int  cut, c, n;
    bit  b1, b2, wait_path, bad_cmd;

`ifdef SPI_SLAVE_PARITY_EN
    fb = {frame, (~^frame) ^ bad_par};
`else
    fb = frame;
`endif
    for (int j = 0; j < DATA_W; j++)
      sb[j] = (MSB_FIRST != 0) ? tx_val[DATA_W-1-j] : tx_val[j];
    sb[DATA_W] = ~^tx_val;

    n   = L + 3;
    cut = (rst_at >= 0 && rst_at < L) ? rst_at : L;
    for (int i = 0; i < MAXC; i++) begin
      rxv[i] = 0; cerr[i] = 0; terr[i] = 0; perr[i] = 0; mi[i] = 0; rxd[i] = m_rx;
    end
    b1 = frame[FW-1];
    b2 = frame[FW-2];
    bad_cmd   = (b1 && !m_flag && b2) || (b1 && m_flag && !b2);
    wait_path = 0;
    if (FLEN < cut) begin
      if (PAR == 1 && bad_par) perr[FLEN] = 1;
      else if (bad_cmd) cerr[FLEN] = 1;
      else begin
        rxv[FLEN] = 1;
        for (int i = FLEN; i < MAXC; i++) rxd[i] = frame;
        m_rx = frame;
        if (b1 && !m_flag) m_flag = 1;
        else if (b1) begin
          wait_path = 1;
          if (d >= 0 && d < TX_TIMEOUT) begin
            c = FLEN + 1 + d;
            for (int j = 0; j < SLEN; j++) if (c + j < cut) mi[c+j] = sb[j];
            if (c + SLEN < cut) m_flag = 0;
          end else if (FLEN + TX_TIMEOUT < cut) begin
            terr[FLEN+TX_TIMEOUT] = 1;
            m_flag = 0;
          end
        end
      end
    end
    if (rst_at >= 0 && rst_at < L) begin
      for (int i = rst_at; i < MAXC; i++) rxd[i] = '0;
      m_flag = 0;
      m_rx   = '0;
    end
    for (int i = 0; i < MAXC; i++)
      ex[i] = {rxd[i], rxv[i], cerr[i], terr[i], perr[i], mi[i], (i < cut)};

    for (int i = 0; i < n; i++) begin
      rst     = (i == rst_at);
      ss_n    = (i >= L);
      mosi    = (i >= 1 && i <= FLEN) ? fb[FLEN-i] : 1'($urandom);
      tx_data = DATA_W'($urandom);
      if (d >= 0 && i == FLEN + 1 + d) begin
        tx_valid = 1'b1;
        tx_data  = tx_val;
      end else if (wait_path && i > FLEN && i <= FLEN + TX_TIMEOUT) tx_valid = 1'b0;
      else tx_valid = 1'($urandom);
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), 64'(obs()), 64'(ex[i]));
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    int rd, rl;
    bit bp;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset", 64'(obs()), 64'(0));
    rst = 1'b0; m_flag = 0; m_rx = '0;

    run_txn("wr055",   10'h055, 0, -1, LFULL, -1, 8'h00);
    run_txn("wr1AA",   10'h1AA, 0, -1, LFULL, -1, 8'h00);
    run_txn("ra203",   10'h203, 0, -1, LFULL, -1, 8'h00);
    run_txn("rdA5",    10'h3C3, 0,  1, LFULL, -1, 8'hA5);
    run_txn("ra_f0",   10'h2C0, 0, -1, LFULL, -1, 8'h00);
    run_txn("rd_edge", 10'h3E1, 0, TX_TIMEOUT-1, LFULL, -1, 8'h3C);
    run_txn("cmd11",   10'h3F0, 0, -1, LFULL, -1, 8'h00);
    run_txn("ra201",   10'h201, 0, -1, LFULL, -1, 8'h00);
    run_txn("cmd10",   10'h280, 0, -1, LFULL, -1, 8'h00);
    run_txn("rd_to",   10'h3AB, 0, -1, LFULL, -1, 8'h00);
    run_txn("ra2AA",   10'h2AA, 0, -1, LFULL, -1, 8'h00);
    run_txn("rd_late", 10'h355, 0, TX_TIMEOUT, LFULL, -1, 8'h77);
    run_txn("abort5",  10'h0FF, 0, -1, 6, -1, 8'h00);
    run_txn("par_bad", 10'h055, 1, -1, LFULL, -1, 8'h00);
    run_txn("ra_r",    10'h203, 0, -1, LFULL, -1, 8'h00);
    run_txn("rst_snd", 10'h3C3, 0,  0, FLEN+5, FLEN+4, 8'h96);
    run_txn("post_rst",10'h1AA, 0, -1, LFULL, -1, 8'h00);

    for (int t = 0; t < 60; t++) begin
      f  = FW'($urandom);
      rd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TX_TIMEOUT + 1));
      rl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LFULL)) : LFULL;
      bp = (PAR == 1) && ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rnd%0d", t), f, bp, rd, rl, -1, DATA_W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised next-generation SPI slave front end for the single-port RAM.
- Deserialises MOSI command frames of DATA_W+2 bits into parallel rx_data/rx_valid words.
- Serialises RAM read data onto MISO. Adds bit-order selection, command checking, a tx_valid timeout and error flags.
- SPI bit clock equals the system clock (one MOSI bit sampled per clk while selected).

Parameters:
DATA_W, 8, width of address and data payload; frame width FW = DATA_W+2
MSB_FIRST, 1, 1 = MISO shifts tx_data MSB first, 0 = LSB first (MOSI is always MSB first)
TX_TIMEOUT, 16, max cycles waited for tx_valid after a read-data frame (>=1)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous active-high reset
ss_n  in  1  slave select, active low
mosi  in  1  serial in from master
tx_data  in  DATA_W  read data from RAM
tx_valid  in  1  tx_data valid strobe
miso  out  1  serial out to master
rx_data  out  DATA_W+2  frame to RAM; [FW-1:FW-2] = cmd (00 wr addr, 01 wr data, 10 rd addr, 11 rd data)
rx_valid  out  1  one-cycle strobe, rx_data valid
busy  out  1  high in every state except IDLE
cmd_err  out  1  one-cycle pulse: cmd bits inconsistent with path
timeout_err  out  1  one-cycle pulse: tx_valid not seen within TX_TIMEOUT
parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 when feature compiled out)

Behaviour:
- Reset: all outputs 0, addr_flag=0, counters/shift regs 0, state IDLE. rst dominates all other inputs.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- ss_n=1 in any non-IDLE state: next state IDLE; counters and shift register cleared; any in-flight frame discarded (no rx_valid); addr_flag retained.
- IDLE: ss_n=0 -> CHK_CMD next cycle. miso=0.
- CHK_CMD: sample mosi as frame bit FW-1 into the shift register.
  - mosi=0 -> WRITE.
  - mosi=1 and addr_flag=1 -> READ_DATA.
  - mosi=1 and addr_flag=0 -> READ_ADD.
- WRITE / READ_ADD / READ_DATA: shift the remaining FW-1 bits, one per cycle, MSB first.
  - On the cycle the last bit is sampled, the full frame is registered into rx_data and rx_valid is high the following cycle for exactly 1 cycle.
  - Frame latency: first bit in CHK_CMD, rx_valid FW cycles later.
- Command check, applied at frame completion:
  - READ_ADD requires cmd=10; READ_DATA requires cmd=11.
  - On mismatch: rx_valid stays 0, cmd_err pulses, state goes to DONE, addr_flag unchanged.
  - WRITE accepts 00/01; cmd bit 1 is 0 by construction.
- WRITE, on completion: -> DONE.
- READ_ADD, on completion: addr_flag <= 1 -> DONE.
- READ_DATA, on completion: -> WAIT_TX; timeout counter = 0.
- WAIT_TX:
  - tx_valid=1 -> capture tx_data, -> SEND.
  - Counter reaching TX_TIMEOUT without tx_valid -> timeout_err pulse, addr_flag <= 0, -> DONE.
  - tx_valid arriving in the same cycle the counter reaches TX_TIMEOUT counts as captured (no error).
- SEND:
  - Drives one bit per cycle on miso for DATA_W cycles; the first bit is valid the cycle after capture. Order is per MSB_FIRST.
  - Then addr_flag <= 0 -> DONE.
- DONE: miso=0, mosi ignored, remain until ss_n=1. A new transaction needs ss_n to deassert and reassert.
- tx_valid outside WAIT_TX is ignored.
- rx_data holds its last value until the next completed frame; it does not clear in IDLE.

Optional Feature:
- Macro SPI_SLAVE_PARITY_EN.
- Defined:
  - Every MOSI frame carries one extra trailing odd-parity bit covering all FW bits, so frame length is FW+1 cycles.
  - On mismatch: rx_valid suppressed, parity_err pulses, -> DONE.
  - SEND appends one odd-parity bit over the DATA_W data bits after the data, so SEND lasts DATA_W+1 cycles.
- Undefined: frames are FW bits, SEND is DATA_W cycles, parity_err is constant 0.

Test Plan:
- DATA_W=8: ss_n low, mosi 00_0101_0101 -> rx_data=0x055, rx_valid single pulse 10 cycles after CHK_CMD; then 01_1010_1010 in a new transaction -> rx_data=0x1AA.
- Read address 10_0000_0011 then new transaction with read data 11_xxxx_xxxx; tx_valid with tx_data=0xA5 two cycles later -> miso 1,0,1,0,0,1,0,1 (MSB_FIRST=1); addr_flag cleared after.
- Read data attempted with addr_flag=0 (mosi 1 in CHK_CMD, frame 10...) -> READ_ADD path taken, addr_flag set. Frame 11_... sent via the READ_ADD path -> cmd_err pulse, no rx_valid.
- Read data frame with tx_valid never asserted -> timeout_err pulse exactly TX_TIMEOUT=16 cycles after entering WAIT_TX; addr_flag=0.
- ss_n raised after 5 frame bits -> IDLE next cycle, no rx_valid; rst asserted mid-SEND -> all outputs 0 next cycle.
- With SPI_SLAVE_PARITY_EN: frame 0x055 + parity 1 -> rx_valid. Same frame with parity 0 -> parity_err pulse, no rx_valid.
